voice_mix_engine: RTL and testbench
===================================

VOICE_MIX_ENGINE -- requirements
Module: voice_mix_engine

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 16, voice slot count; power of two, 2..256.
REQ-002 SHALL have parameter PHASE_W, default 32, phase accumulator width.
REQ-003 SHALL have parameter WT_ADDR_W, default 10, wavetable phase width; the top WT_ADDR_W bits of the accumulator.
REQ-004 SHALL have parameters WAVE_W, default 16, wavetable sample width; GAIN_W, default 8, unsigned gain width; OUT_W, default 24, mixed output width.
REQ-005 SHALL have ports, one per line:
 clk  in  1  sole clock, rising edge
 reset  in  1  asynchronous, active-low reset (asserted at 0)
 upd_valid  in  1  parameter update offered
 upd_ready  out  1  update accepted when both high on a clk edge
 upd_voice  in  clog2(NUM_VOICES)  target voice slot
 upd_gate  in  1  1 = note on, 0 = note off
 upd_delta  in  PHASE_W  phase increment (tuning code)
 upd_gain  in  GAIN_W  voice gain (velocity-derived)
 wt_phase  out  WT_ADDR_W  phase presented to external wavetable
 wt_sample  in  signed WAVE_W  wavetable sample, valid exactly 1 cycle after wt_phase
 out_sample  out  signed OUT_W  mixed frame sample, held between frames
 out_valid  out  1  one-cycle pulse when out_sample updates
 active_count  out  clog2(NUM_VOICES)+1  gated voices at the last frame end

Function
REQ-006 SHALL hold per-voice state {gate, delta, gain, phase} in internal storage indexed by voice number.
REQ-007 SHALL run a 4-state FSM per voice: LOAD (read slot v) -> STEP (phase += delta mod 2^PHASE_W, write back, drive wt_phase from new phase) -> WAIT (wavetable latency) -> MIX (accumulate) -> LOAD of v+1.
REQ-008 SHALL process voices 0..NUM_VOICES-1 in order; one frame = 4*NUM_VOICES cycles; voice counter wraps from NUM_VOICES-1 to 0.
REQ-009 SHALL advance the phase of a voice only while its gate=1; a gated-off voice keeps its phase, drives wt_phase 0 and contributes 0.
REQ-010 SHALL compute contribution = (wt_sample * gain) arithmetically shifted right by GAIN_W, signed, full precision before the shift.
REQ-011 SHALL accumulate in OUT_W+clog2(NUM_VOICES) signed bits with no intermediate overflow.
REQ-012 SHALL, in MIX of voice NUM_VOICES-1, load out_sample with the accumulator sum saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1], pulse out_valid for that cycle, clear the accumulator and update active_count.
REQ-013 SHALL drive upd_ready=1 in LOAD, WAIT and MIX and 0 in STEP (storage write-back cycle); at most one update is accepted per cycle.
REQ-014 SHALL write gate, delta and gain of slot upd_voice on acceptance; a 0->1 gate transition SHALL also clear that slot's phase to 0.
REQ-015 SHALL, when an accepted update targets the voice currently between LOAD and MIX, finish that voice with the values latched at LOAD; the new values apply from the next frame.
REQ-016 SHALL treat a re-trigger (gate 1 while already 1) as delta/gain update without phase reset.
REQ-017 SHALL never drop an update offered while upd_ready=1; upd_valid held during STEP SHALL be accepted on the following cycle.

Reset
REQ-018 SHALL, while reset=0, force FSM to LOAD, voice counter 0, accumulator 0, out_sample 0, out_valid 0, active_count 0, wt_phase 0, upd_ready 0.
REQ-019 SHALL clear gate and phase of every slot on reset (may take NUM_VOICES cycles after release, with upd_ready=0 and no out_valid until done); delta and gain need not be cleared.
REQ-020 SHALL abandon a partially accumulated frame on reset assertion; the first out_valid after release is a complete frame.

Verification
REQ-021 Reset release, no updates -> out_valid every 4*NUM_VOICES cycles (64 at default), out_sample=0, active_count=0.
REQ-022 Voice 3 on, delta=2^22, gain=255, wavetable returns constant 1000 -> out_sample=996 each frame, wt_phase for voice 3 increments by 1 per frame, active_count=1.
REQ-023 All 16 voices on, gain=255, wt_sample=32767 -> out_sample=16*32639=522224 (no saturation); OUT_W=16 build -> out_sample=32767.
REQ-024 upd_valid held asserted across STEP -> upd_ready low in STEP, update accepted next cycle, exactly one slot write.
REQ-025 Note-off voice 3 then note-on voice 3 -> phase restarts at 0 (wt_phase=delta>>(PHASE_W-WT_ADDR_W) on first step); note-off alone keeps phase, contributes 0.
REQ-026 reset=0 mid-frame with 5 voices on -> outputs per REQ-018 immediately; after release all gates 0 and next out_sample=0.

Source files
------------

// File: rtl/voice_mix_engine.sv
// voice_mix_engine: time-multiplexed wavetable voice mixer.
// Each voice slot is visited for four cycles per frame; the per-voice
// contributions are summed into a wide accumulator and the saturated
// frame sum is published once per frame.
//
// state  | meaning
// -------+-----------------------------------------------------------
// LOAD   | latch gate/delta/gain/phase of the current voice slot
// STEP   | advance phase, write it back, present wavetable address
// WAIT   | wavetable read latency
// MIX    | accumulate contribution; last voice closes the frame
module voice_mix_engine #(
   parameter int NUM_VOICES = 16,
   parameter int PHASE_W    = 32,
   parameter int WT_ADDR_W  = 10,
   parameter int WAVE_W     = 16,
   parameter int GAIN_W     = 8,
   parameter int OUT_W      = 24
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            upd_valid,
   output logic                            upd_ready,
   input  logic [$clog2(NUM_VOICES)-1:0]   upd_voice,
   input  logic                            upd_gate,
   input  logic [PHASE_W-1:0]              upd_delta,
   input  logic [GAIN_W-1:0]               upd_gain,
   output logic [WT_ADDR_W-1:0]            wt_phase,
   input  logic signed [WAVE_W-1:0]        wt_sample,
   output logic signed [OUT_W-1:0]         out_sample,
   output logic                            out_valid,
   output logic [$clog2(NUM_VOICES):0]     active_count
);

   localparam int VW     = $clog2(NUM_VOICES);
   localparam int ACC_W  = OUT_W + VW;
   localparam int PROD_W = WAVE_W + GAIN_W + 1;
   localparam int CON_W  = WAVE_W + 1;

   localparam logic [1:0] S_LOAD = 2'd0;
   localparam logic [1:0] S_STEP = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;
   localparam logic [1:0] S_MIX  = 2'd3;

   logic               gate_mem  [NUM_VOICES];
   logic [PHASE_W-1:0] phase_mem [NUM_VOICES];
   logic [PHASE_W-1:0] delta_mem [NUM_VOICES];
   logic [GAIN_W-1:0]  gain_mem  [NUM_VOICES];

   logic [1:0]         state;
   logic [VW-1:0]      voice;
   logic               run;

   logic               cur_gate;
   logic [PHASE_W-1:0] cur_phase;
   logic [PHASE_W-1:0] cur_delta;
   logic [GAIN_W-1:0]  cur_gain;

   logic signed [ACC_W-1:0] acc;
   logic [VW:0]             gate_cnt;

   logic                    accept;
   logic                    last_voice;
   logic [PHASE_W-1:0]      next_phase;
   logic signed [PROD_W-1:0] product;
   logic signed [CON_W-1:0] contrib;
   logic signed [ACC_W-1:0] contrib_ext;
   logic signed [ACC_W-1:0] acc_sum;
   logic                    sum_fits;
   logic [OUT_W-1:0]        sum_sat;
   logic [VW:0]             gate_inc;
   logic                    unused_prod_lsbs;

   // Updates are refused only in STEP, where the phase write-back owns the slot store.
   assign upd_ready  = run && (state != S_STEP);
   assign accept     = upd_valid && upd_ready;
   assign last_voice = &voice;
   assign next_phase = cur_phase + cur_delta;
   assign gate_inc   = {{VW{1'b0}}, cur_gate};

   // Contribution = floor(sample * gain / 2^GAIN_W); gain is unsigned so it gets a zero sign bit.
   always_comb begin
      product          = PROD_W'($signed(wt_sample)) * PROD_W'($signed({1'b0, cur_gain}));
      contrib          = cur_gate ? $signed(product[PROD_W-1:GAIN_W]) : '0;
      unused_prod_lsbs = ^product[GAIN_W-1:0];
      contrib_ext      = {{(ACC_W-CON_W){contrib[CON_W-1]}}, contrib};
      acc_sum          = acc + contrib_ext;
      sum_fits         = (acc_sum[ACC_W-1:OUT_W-1] == {(ACC_W-OUT_W+1){acc_sum[ACC_W-1]}});
      if (sum_fits)
         sum_sat = acc_sum[OUT_W-1:0];
      else if (acc_sum[ACC_W-1])
         sum_sat = {1'b1, {(OUT_W-1){1'b0}}};
      else
         sum_sat = {1'b0, {(OUT_W-1){1'b1}}};
   end

   // Gate and phase store: cleared on reset, written by updates and by the STEP write-back.
   // A 0->1 gate edge can only hit a slot whose latched gate is 0, so it never races the write-back.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_VOICES; i++) begin
            gate_mem[i]  <= 1'b0;
            phase_mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            gate_mem[upd_voice] <= upd_gate;
            if (upd_gate && !gate_mem[upd_voice])
               phase_mem[upd_voice] <= '0;
         end else if (state == S_STEP && cur_gate) begin
            phase_mem[voice] <= next_phase;
         end
      end
   end

   // Tuning and gain store; values are meaningless until the first note-on writes them.
   always_ff @(posedge clk) begin
      if (accept) begin
         delta_mem[upd_voice] <= upd_delta;
         gain_mem[upd_voice]  <= upd_gain;
      end
   end

   // Voice sequencer, accumulator and frame output.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_LOAD;
         voice        <= '0;
         run          <= 1'b0;
         cur_gate     <= 1'b0;
         cur_phase    <= '0;
         cur_delta    <= '0;
         cur_gain     <= '0;
         acc          <= '0;
         gate_cnt     <= '0;
         wt_phase     <= '0;
         out_sample   <= '0;
         out_valid    <= 1'b0;
         active_count <= '0;
      end else begin
         run       <= 1'b1;
         out_valid <= 1'b0;
         if (run) begin
            case (state)
               S_LOAD: begin
                  cur_gate  <= gate_mem[voice];
                  cur_phase <= phase_mem[voice];
                  cur_delta <= delta_mem[voice];
                  cur_gain  <= gain_mem[voice];
                  state     <= S_STEP;
               end
               S_STEP: begin
                  wt_phase <= cur_gate ? next_phase[PHASE_W-1 -: WT_ADDR_W] : '0;
                  state    <= S_WAIT;
               end
               S_WAIT: begin
                  state <= S_MIX;
               end
               S_MIX: begin
                  if (last_voice) begin
                     out_sample   <= sum_sat;
                     out_valid    <= 1'b1;
                     active_count <= gate_cnt + gate_inc;
                     acc          <= '0;
                     gate_cnt     <= '0;
                  end else begin
                     acc      <= acc_sum;
                     gate_cnt <= gate_cnt + gate_inc;
                  end
                  voice <= voice + VW'(1);
                  state <= S_LOAD;
               end
               default: state <= S_LOAD;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_voice_mix_engine.sv
// Bench for voice_mix_engine: frame-level reference model with random and directed updates.
module tb_voice_mix_engine;

   localparam int NV = 16;

   logic               clk = 1'b0;
   logic               reset;
   logic               upd_valid;
   logic               upd_ready;
   logic [3:0]         upd_voice;
   logic               upd_gate;
   logic [31:0]        upd_delta;
   logic [7:0]         upd_gain;
   logic [9:0]         wt_phase;
   logic signed [15:0] wt_sample;
   logic signed [23:0] out_sample;
   logic               out_valid;
   logic [4:0]         active_count;

   logic               upd_ready16;
   logic [9:0]         wt_phase16;
   logic signed [15:0] out_sample16;
   logic               out_valid16;
   logic [4:0]         active_count16;

   always #5 clk = ~clk;

   voice_mix_engine dut (
      .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready),
      .upd_voice(upd_voice), .upd_gate(upd_gate), .upd_delta(upd_delta), .upd_gain(upd_gain),
      .wt_phase(wt_phase), .wt_sample(wt_sample), .out_sample(out_sample),
      .out_valid(out_valid), .active_count(active_count)
   );

   voice_mix_engine #(.OUT_W(16)) dut16 (
      .clk(clk), .reset(reset), .upd_valid(upd_valid), .upd_ready(upd_ready16),
      .upd_voice(upd_voice), .upd_gate(upd_gate), .upd_delta(upd_delta), .upd_gain(upd_gain),
      .wt_phase(wt_phase16), .wt_sample(wt_sample), .out_sample(out_sample16),
      .out_valid(out_valid16), .active_count(active_count16)
   );

   typedef struct {
      int          voice;
      bit          gate;
      logic [31:0] delta;
      int          gain;
   } upd_t;

   upd_t        q[$];
   upd_t        cur_upd;
   bit          offer;

   bit          m_gate  [NV];
   logic [31:0] m_delta [NV];
   logic [31:0] m_phase [NV];
   int          m_gain  [NV];

   bit          c_gate;
   logic [31:0] c_phase;
   logic [31:0] c_delta;
   int          c_gain;
   logic [9:0]  e_wt;
   longint      acc;
   int          act;
   longint      e_out24;
   longint      e_out16;
   int          e_act;
   int          t;
   int          wave_mode;
   int          wave_const;
   int          n_vec;
   int          n_err;

   function automatic int wave(logic [9:0] ph);
      int x;
      if (wave_mode != 0) return wave_const;
      x = int'(ph);
      x = (x * 40503 + 12345) & 32'h0000_FFFF;
      return x - 32768;
   endfunction

   function automatic longint sat(longint a, int w);
      longint hi, lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (a > hi) return hi;
      if (a < lo) return lo;
      return a;
   endfunction

   // external wavetable: one cycle read latency
   always @(posedge clk) wt_sample <= 16'(wave(wt_phase));

   task automatic chk(input string tag, input longint got, input longint want);
      n_vec++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, want, t);
      end
   endtask

   task automatic push_upd(input int v, input bit g, input logic [31:0] d, input int gn);
      upd_t u;
      u.voice = v; u.gate = g; u.delta = d; u.gain = gn;
      q.push_back(u);
   endtask

   task automatic model_reset();
      for (int i = 0; i < NV; i++) begin
         m_gate[i]  = 1'b0;
         m_phase[i] = '0;
      end
      acc = 0; act = 0; e_out24 = 0; e_out16 = 0; e_act = 0;
      offer = 1'b0;
      q.delete();
      upd_valid = 1'b0;
   endtask

   // One cycle of the reference: observe, advance the model, then offer stimulus.
   task automatic run_cycle(input bit rnd);
      int     stage, v, vv;
      longint p;
      stage = t % 4;
      v     = (t / 4) % NV;
      if (stage == 0 && v == 0) begin
         chk("out_valid", out_valid, 1);
         chk("out_valid_w16", out_valid16, 1);
         chk("out_sample", out_sample, e_out24);
         chk("out_sample_w16", out_sample16, e_out16);
         chk("active_count", active_count, e_act);
      end else begin
         chk("out_valid_idle", out_valid, 0);
      end
      chk("upd_ready", upd_ready, (stage != 1) ? 1 : 0);
      chk("upd_ready_w16", upd_ready16, (stage != 1) ? 1 : 0);
      case (stage)
         0: begin
            c_gate  = m_gate[v];
            c_phase = m_phase[v];
            c_delta = m_delta[v];
            c_gain  = m_gain[v];
         end
         1: begin
            if (c_gate) begin
               m_phase[v] = c_phase + c_delta;
               e_wt = m_phase[v][31:22];
            end else begin
               e_wt = '0;
            end
         end
         2: begin
            chk("wt_phase", wt_phase, e_wt);
            chk("wt_phase_w16", wt_phase16, e_wt);
         end
         default: begin
            if (c_gate) begin
               p = longint'(wave(e_wt)) * longint'(c_gain);
               acc += (p >>> 8);
               act++;
            end
            if (v == NV - 1) begin
               e_out24 = sat(acc, 24);
               e_out16 = sat(acc, 16);
               e_act   = act;
               acc = 0;
               act = 0;
            end
         end
      endcase
      if (!offer) begin
         if (q.size() > 0) begin
            cur_upd = q.pop_front();
            offer = 1'b1;
         end else if (rnd && $urandom_range(7) == 0) begin
            cur_upd.voice = int'($urandom_range(NV - 1));
            cur_upd.gate  = ($urandom_range(3) != 0);
            cur_upd.delta = $urandom;
            cur_upd.gain  = int'($urandom_range(255));
            offer = 1'b1;
         end
      end
      upd_valid = offer;
      upd_voice = 4'(cur_upd.voice);
      upd_gate  = cur_upd.gate;
      upd_delta = cur_upd.delta;
      upd_gain  = 8'(cur_upd.gain);
      if (offer && stage != 1) begin
         vv = cur_upd.voice;
         if (cur_upd.gate && !m_gate[vv]) m_phase[vv] = '0;
         m_gate[vv]  = cur_upd.gate;
         m_delta[vv] = cur_upd.delta;
         m_gain[vv]  = cur_upd.gain;
         offer = 1'b0;
      end
   endtask

   task automatic align();
      int k;
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!out_valid && k < 4 * NV + 16);
      model_reset();
      t = 0;
      run_cycle(1'b0);
      t++;
   endtask

   task automatic run_cycles(input int n, input bit rnd);
      repeat (n) begin
         @(negedge clk);
         run_cycle(rnd);
         t++;
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, out_valid, 0);
      chk({tag, "_out_sample"}, out_sample, 0);
      chk({tag, "_active_count"}, active_count, 0);
      chk({tag, "_wt_phase"}, wt_phase, 0);
      chk({tag, "_upd_ready"}, upd_ready, 0);
      chk({tag, "_upd_ready_w16"}, upd_ready16, 0);
      chk({tag, "_out_sample_w16"}, out_sample16, 0);
   endtask

   initial begin
      n_vec = 0; n_err = 0; t = 0;
      reset = 1'b0;
      upd_valid = 1'b0; upd_voice = '0; upd_gate = 1'b0; upd_delta = '0; upd_gain = '0;
      cur_upd.voice = 0; cur_upd.gate = 1'b0; cur_upd.delta = '0; cur_upd.gain = 0;
      for (int i = 0; i < NV; i++) begin
         m_delta[i] = '0;
         m_gain[i]  = 0;
      end
      wave_mode = 1; wave_const = 0;
      offer = 1'b0;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset = 1'b1;

      // idle frames
      align();
      run_cycles(3 * 4 * NV, 1'b0);

      // voice 3, constant wavetable 1000
      wave_const = 1000;
      push_upd(3, 1'b1, 32'h0040_0000, 255);
      run_cycles(4 * 4 * NV, 1'b0);

      // note-off keeps phase, then note-on restarts it
      push_upd(3, 1'b0, 32'h0040_0000, 255);
      run_cycles(2 * 4 * NV, 1'b0);
      push_upd(3, 1'b1, 32'h0123_4567, 200);
      run_cycles(2 * 4 * NV, 1'b0);
      push_upd(3, 1'b1, 32'h0200_0000, 128);
      run_cycles(2 * 4 * NV, 1'b0);

      // random updates against a varying wavetable
      wave_mode = 0;
      run_cycles(30 * 4 * NV, 1'b1);

      // all voices at full gain, positive then negative full scale
      wave_mode = 1;
      wave_const = 32767;
      for (int v = 0; v < NV; v++) push_upd(v, 1'b1, $urandom, 255);
      run_cycles(3 * 4 * NV, 1'b0);
      wave_const = -32768;
      run_cycles(2 * 4 * NV, 1'b0);

      // leave five voices on, then reset mid-frame
      wave_mode = 0;
      for (int v = 5; v < NV; v++) push_upd(v, 1'b0, '0, 0);
      run_cycles(2 * 4 * NV, 1'b0);
      run_cycles(37, 1'b0);
      #2 reset = 1'b0;
      upd_valid = 1'b0;
      #1 chk_reset_outputs("midrst");
      repeat (4) @(negedge clk);
      reset = 1'b1;
      align();
      run_cycles(2 * 4 * NV, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
